// File: rtl/fetch_stage.sv
// fetch_stage: RV64 IF stage owning the PC and the IF/ID register, with stall hold and redirect squash.
module fetch_stage #(
    parameter int                      PC_WIDTH   = 64,
    parameter int                      INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0]   NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  branchTaken,
    input  logic [PC_WIDTH-1:0]   branchTarget,
    input  logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   instAddr,
    output logic [PC_WIDTH-1:0]   ifIdPc,
    output logic [INST_WIDTH-1:0] ifIdInst,
    output logic                  ifIdValid,
    output logic                  misalignErr,
    output logic [31:0]           fetchCount
);
    typedef enum logic {BOOT, RUN} state_t;
    state_t                state, nextState;
    logic [PC_WIDTH-1:0]   pc, pcNext, ifIdPcNext;
    logic [INST_WIDTH-1:0] ifIdInstNext;
    logic                  ifIdValidNext, misalignNext;
    logic [31:0]           countNext;
    assign instAddr = pc;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            ifIdPc      <= '0;
            ifIdInst    <= NOP_INST;
            ifIdValid   <= 1'b0;
            misalignErr <= 1'b0;
            fetchCount  <= '0;
        end else begin
            state       <= nextState;
            pc          <= pcNext;
            ifIdPc      <= ifIdPcNext;
            ifIdInst    <= ifIdInstNext;
            ifIdValid   <= ifIdValidNext;
            misalignErr <= misalignNext;
            fetchCount  <= countNext;
        end
    end
    // Redirect beats stall; BOOT ignores both and just holds for one cycle.
    always_comb begin
        nextState     = RUN;
        pcNext        = pc;
        ifIdPcNext    = ifIdPc;
        ifIdInstNext  = ifIdInst;
        ifIdValidNext = ifIdValid;
        misalignNext  = 1'b0;
        countNext     = fetchCount;
        if (state == RUN) begin
            if (branchTaken) begin
                pcNext        = {branchTarget[PC_WIDTH-1:2], 2'b00};
                ifIdPcNext    = '0;
                ifIdInstNext  = NOP_INST;
                ifIdValidNext = 1'b0;
                misalignNext  = |branchTarget[1:0];
            end else if (!stall) begin
                pcNext        = pc + PC_WIDTH'(4);
                ifIdPcNext    = pc;
                ifIdInstNext  = inst;
                ifIdValidNext = 1'b1;
                countNext     = fetchCount + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;
    logic        clk = 1'b0, reset_n = 1'b0, stall = 1'b0, branchTaken = 1'b0;
    logic [63:0] branchTarget = '0;
    logic [31:0] inst;
    logic [63:0] instAddr, ifIdPc;
    logic [31:0] ifIdInst, fetchCount;
    logic        ifIdValid, misalignErr;
    typedef struct packed {logic [63:0] pc; logic [31:0] inst;} ent_t;
    ent_t        sb[$];
    ent_t        e;
    int          nTests = 0, nFail = 0;
    logic [63:0] mPc, eIfPc;
    logic [31:0] mCount, eIfInst;
    logic        eIfValid, eMis, boot;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .inst(inst), .instAddr(instAddr), .ifIdPc(ifIdPc),
        .ifIdInst(ifIdInst), .ifIdValid(ifIdValid), .misalignErr(misalignErr),
        .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'd0:   return 32'h0F053483;
            64'd4:   return 32'h009A84B3;
            64'd8:   return 32'h00148493;
            64'd12:  return 32'h0E953823;
            default: return 32'hC000_0000 ^ a[31:0];
        endcase
    endfunction

    assign inst = imem(instAddr);

    task automatic modelReset();
        mPc = '0; mCount = '0; eIfPc = '0; eIfInst = 32'h13; eIfValid = 1'b0; eMis = 1'b0;
        boot = 1'b1;
        sb.delete();
    endtask

    // Drives one clock's inputs, advances the reference model, pops the scoreboard after the edge.
    task automatic cycle(input logic s, input logic b, input logic [63:0] t);
        logic fetched;
        fetched = 1'b0;
        stall = s; branchTaken = b; branchTarget = t;
        eMis = 1'b0;
        if (boot) boot = 1'b0;
        else if (b) begin
            mPc = {t[63:2], 2'b00};
            eIfPc = '0; eIfInst = 32'h13; eIfValid = 1'b0; eMis = |t[1:0];
        end else if (!s) begin
            sb.push_back('{pc: mPc, inst: imem(mPc)});
            mPc = mPc + 64'd4; mCount = mCount + 32'd1; fetched = 1'b1;
        end
        @(posedge clk);
        #1;
        stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
        if (fetched) begin
            e = sb.pop_front();
            eIfPc = e.pc; eIfInst = e.inst; eIfValid = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        nTests++; if (instAddr !== 64'd0) begin nFail++; $display("FAIL reset_addr got %h exp 0", instAddr); end
        nTests++; if (ifIdValid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b exp 0", ifIdValid); end
        nTests++; if (ifIdInst !== 32'h13) begin nFail++; $display("FAIL reset_inst got %h exp 13", ifIdInst); end
        nTests++; if (fetchCount !== 32'd0) begin nFail++; $display("FAIL reset_count got %0d exp 0", fetchCount); end
        nTests++; if (misalignErr !== 1'b0) begin nFail++; $display("FAIL reset_mis got %b exp 0", misalignErr); end
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, 64'h40);
        nTests++; if (ifIdValid !== 1'b0) begin nFail++; $display("FAIL boot_valid got %b exp 0", ifIdValid); end
        nTests++; if (instAddr !== 64'd0) begin nFail++; $display("FAIL boot_addr got %h exp 0", instAddr); end
    endtask

    task automatic test_seq();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            nTests++; if (ifIdPc !== eIfPc || ifIdInst !== eIfInst || ifIdValid !== 1'b1)
                begin nFail++; $display("FAIL seq_%0d got %h/%h/%b exp %h/%h/1", i, ifIdPc, ifIdInst, ifIdValid, eIfPc, eIfInst); end
            nTests++; if (instAddr !== mPc) begin nFail++; $display("FAIL seq_addr_%0d got %h exp %h", i, instAddr, mPc); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, '0);
            nTests++; if (instAddr !== 64'd12 || ifIdPc !== 64'd8 || ifIdInst !== 32'h00148493 || ifIdValid !== 1'b1)
                begin nFail++; $display("FAIL stall_%0d got %h/%h/%h exp 12/8/00148493", i, instAddr, ifIdPc, ifIdInst); end
            nTests++; if (fetchCount !== 32'd3) begin nFail++; $display("FAIL stall_count_%0d got %0d exp 3", i, fetchCount); end
        end
        cycle(1'b0, 1'b0, '0);
        nTests++; if (ifIdPc !== eIfPc || ifIdInst !== eIfInst || eIfInst !== 32'h0E953823)
            begin nFail++; $display("FAIL stall_resume got %h/%h exp %h/%h", ifIdPc, ifIdInst, eIfPc, eIfInst); end
        nTests++; if (fetchCount !== 32'd4) begin nFail++; $display("FAIL seq_count got %0d exp 4", fetchCount); end
    endtask

    task automatic test_branch_stall();
        cycle(1'b1, 1'b1, 64'h4);
        nTests++; if (instAddr !== 64'h4 || ifIdValid !== 1'b0 || ifIdInst !== 32'h13 || ifIdPc !== 64'd0)
            begin nFail++; $display("FAIL br_stall got %h/%b/%h/%h exp 4/0/13/0", instAddr, ifIdValid, ifIdInst, ifIdPc); end
        nTests++; if (fetchCount !== mCount) begin nFail++; $display("FAIL br_count got %0d exp %0d", fetchCount, mCount); end
        cycle(1'b0, 1'b0, '0);
        nTests++; if (ifIdInst !== 32'h009A84B3 || ifIdPc !== 64'h4 || ifIdValid !== 1'b1)
            begin nFail++; $display("FAIL br_after got %h/%h/%b exp 009A84B3/4/1", ifIdInst, ifIdPc, ifIdValid); end
    endtask

    task automatic test_misalign();
        cycle(1'b0, 1'b1, 64'h6);
        nTests++; if (instAddr !== 64'h4 || misalignErr !== 1'b1)
            begin nFail++; $display("FAIL mis_redirect got %h/%b exp 4/1", instAddr, misalignErr); end
        cycle(1'b0, 1'b0, '0);
        nTests++; if (misalignErr !== 1'b0 || ifIdInst !== eIfInst)
            begin nFail++; $display("FAIL mis_pulse got %b/%h exp 0/%h", misalignErr, ifIdInst, eIfInst); end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, 64'h23);
        nTests++; if (misalignErr !== 1'b1 || instAddr !== 64'h20)
            begin nFail++; $display("FAIL b2b_first got %b/%h exp 1/20", misalignErr, instAddr); end
        cycle(1'b0, 1'b1, 64'h100);
        nTests++; if (misalignErr !== 1'b0 || instAddr !== 64'h100 || ifIdValid !== 1'b0)
            begin nFail++; $display("FAIL b2b_second got %b/%h/%b exp 0/100/0", misalignErr, instAddr, ifIdValid); end
        cycle(1'b0, 1'b0, '0);
        nTests++; if (ifIdPc !== eIfPc || ifIdInst !== eIfInst || fetchCount !== mCount)
            begin nFail++; $display("FAIL b2b_fetch got %h/%h/%0d exp %h/%h/%0d", ifIdPc, ifIdInst, fetchCount, eIfPc, eIfInst, mCount); end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        nTests++; if (instAddr !== 64'd0 || ifIdValid !== 1'b0 || ifIdInst !== 32'h13 || ifIdPc !== 64'd0 || fetchCount !== 32'd0 || misalignErr !== 1'b0)
            begin nFail++; $display("FAIL async_reset got %h/%b/%h/%h/%0d/%b", instAddr, ifIdValid, ifIdInst, ifIdPc, fetchCount, misalignErr); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, '0);
        nTests++; if (ifIdValid !== 1'b0 || fetchCount !== 32'd0)
            begin nFail++; $display("FAIL async_boot got %b/%0d exp 0/0", ifIdValid, fetchCount); end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        nTests++; if (instAddr !== 64'hFFFF_FFFF_FFFF_FFFC || misalignErr !== 1'b0)
            begin nFail++; $display("FAIL wrap_redirect got %h/%b", instAddr, misalignErr); end
        cycle(1'b0, 1'b0, '0);
        nTests++; if (instAddr !== 64'd0 || ifIdPc !== eIfPc || ifIdInst !== eIfInst || fetchCount !== 32'd1)
            begin nFail++; $display("FAIL wrap got %h/%h/%h/%0d exp 0/%h/%h/1", instAddr, ifIdPc, ifIdInst, fetchCount, eIfPc, eIfInst); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_branch_stall();
        test_misalign();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
